// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the convolution stream controller
package conv_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } conv_state_t;

    typedef enum logic {
        STRIDE1 = 1'b0,
        STRIDE2 = 1'b1
    } conv_stride_t;

    // Weight words fetched per layer: one per kernel tap per input channel.
    function automatic int weight_words(input int in_ch, input int ksize);
        return in_ch * ksize * ksize;
    endfunction

endpackage

// File: rtl/conv_pos_cnt.sv
// rtl/conv_pos_cnt.sv - pixel row/column tracker with kernel-window flags
// Ports: clear restarts at (0,0); advance registers the next position as the
// current output pixel; stride2 selects even-offset windows only.
// orow_cnt/ocol_cnt/orow_flag describe the current pixel and hold while idle;
// owin_valid pulses with the pixel when a full (stride-aligned) window ends there.
module conv_pos_cnt #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int KSIZE = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      advance,
    input  logic                      stride2,
    output logic [$clog2(IMG_H)-1:0]  orow_cnt,
    output logic [$clog2(IMG_W)-1:0]  ocol_cnt,
    output logic                      orow_flag,
    output logic                      owin_valid
);

    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] ROW_K = RW'(KSIZE - 1);
    localparam logic [CW-1:0] COL_K = CW'(KSIZE - 1);
    // (pos - (KSIZE-1)) is even exactly when pos[0] matches this parity bit.
    localparam logic          KPAR  = 1'((KSIZE - 1) % 2);

    logic [RW-1:0] nrow;
    logic [CW-1:0] ncol;
    logic          win_next;

    always_comb begin
        win_next = (nrow >= ROW_K) && (ncol >= COL_K);
        if (stride2) begin
            win_next = win_next && (nrow[0] == KPAR) && (ncol[0] == KPAR);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            nrow       <= '0;
            ncol       <= '0;
            orow_cnt   <= '0;
            ocol_cnt   <= '0;
            orow_flag  <= 1'b0;
            owin_valid <= 1'b0;
        end else begin
            owin_valid <= advance && win_next;
            if (advance) begin
                orow_cnt  <= nrow;
                ocol_cnt  <= ncol;
                orow_flag <= (nrow >= ROW_K);
                if (ncol == CW'(IMG_W - 1)) begin
                    ncol <= '0;
                    nrow <= (nrow == RW'(IMG_H - 1)) ? '0 : nrow + 1'b1;
                end else begin
                    ncol <= ncol + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_stream_ctrl.sv
// rtl/conv_stream_ctrl.sv - weight load and pixel streaming controller for a conv engine
// Optional feature macro: CONV_STREAM_STAT_EN (adds ostat_pix frame pixel counter).
// Ports: idata/idata_empty/odata_rd - data FIFO; ipara_empty/opara_rd - weight FIFO;
// istart/istride - frame start and stride select; odata_ch/odata_valid/orow_cnt/
// ocol_cnt/orow_flag/owin_valid - pixel stream out; opara_valid - per-channel weight
// strobe; ifinish_flag/oover_flag - downstream done handshake and frame-done pulse.
module conv_stream_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int IN_CH  = 3,
    parameter int KSIZE  = 3,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_W-1:0]           idata,
    input  logic                        idata_empty,
    output logic                        odata_rd,
    input  logic                        ipara_empty,
    output logic                        opara_rd,
    input  logic                        istart,
    input  logic                        istride,
    output logic [IN_CH*PIX_W-1:0]      odata_ch,
    output logic                        odata_valid,
    output logic [$clog2(IMG_H)-1:0]    orow_cnt,
    output logic [$clog2(IMG_W)-1:0]    ocol_cnt,
    output logic                        orow_flag,
    output logic                        owin_valid,
    output logic [IN_CH-1:0]            opara_valid,
    input  logic                        ifinish_flag,
    output logic                        oover_flag
`ifdef CONV_STREAM_STAT_EN
    ,
    output logic [$clog2(IMG_W*IMG_H+1)-1:0] ostat_pix
`endif
);

    localparam int KK   = KSIZE * KSIZE;
    localparam int NW   = weight_words(IN_CH, KSIZE);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int WPW  = $clog2(NW + 1);
    localparam int KKW  = (KK > 1) ? $clog2(KK) : 1;
    localparam int CHW  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int PPW  = $clog2(NPIX + 1);
    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);

    conv_state_t  state;
    conv_stride_t stride_q;
    logic [WPW-1:0] wpop;
    logic [KKW-1:0] wk;
    logic [CHW-1:0] wch;
    logic           last_strobe;
    logic [PPW-1:0] ppop;
    logic           data_pend;
    logic           frame_start;
    logic           last_pix;

    assign frame_start = (state == ST_IDLE) && istart;
    // Pops are gated by rst_n so nothing leaves either FIFO while reset is held.
    assign opara_rd = rst_n && (state == ST_LOAD) && !ipara_empty && (wpop != WPW'(NW));
    assign odata_rd = rst_n && (state == ST_STREAM) && !idata_empty && (ppop != PPW'(NPIX));
    assign last_pix = odata_valid && (orow_cnt == RW'(IMG_H - 1)) && (ocol_cnt == CW'(IMG_W - 1));

    generate
        if (DATA_W > IN_CH * PIX_W) begin : g_unused_hi
            logic unused_idata_hi;
            assign unused_idata_hi = &{1'b0, idata[DATA_W-1:IN_CH*PIX_W]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            stride_q    <= STRIDE1;
            wpop        <= '0;
            wk          <= '0;
            wch         <= '0;
            last_strobe <= 1'b0;
            ppop        <= '0;
            data_pend   <= 1'b0;
            odata_valid <= 1'b0;
            odata_ch    <= '0;
            opara_valid <= '0;
            oover_flag  <= 1'b0;
        end else begin
            oover_flag  <= 1'b0;
            // Weight word appears on the FIFO one cycle after its pop.
            opara_valid <= opara_rd ? (IN_CH'(1) << wch) : '0;
            last_strobe <= opara_rd && (wpop == WPW'(NW - 1));
            // Data pop -> word on FIFO next cycle -> registered out the cycle after.
            data_pend   <= odata_rd;
            odata_valid <= data_pend;
            if (data_pend) begin
                odata_ch <= idata[IN_CH*PIX_W-1:0];
            end

            case (state)
                ST_IDLE: begin
                    if (istart) begin
                        stride_q <= conv_stride_t'(istride);
                        wpop     <= '0;
                        wk       <= '0;
                        wch      <= '0;
                        ppop     <= '0;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (opara_rd) begin
                        wpop <= wpop + 1'b1;
                        if (wk == KKW'(KK - 1)) begin
                            wk  <= '0;
                            wch <= wch + 1'b1;
                        end else begin
                            wk <= wk + 1'b1;
                        end
                    end
                    if (last_strobe) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (odata_rd) begin
                        ppop <= ppop + 1'b1;
                    end
                    if (last_pix) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ifinish_flag) begin
                        oover_flag <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    conv_pos_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .KSIZE (KSIZE)
    ) u_pos_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (frame_start),
        .advance    (data_pend),
        .stride2    (stride_q == STRIDE2),
        .orow_cnt   (orow_cnt),
        .ocol_cnt   (ocol_cnt),
        .orow_flag  (orow_flag),
        .owin_valid (owin_valid)
    );

`ifdef CONV_STREAM_STAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || frame_start) begin
            ostat_pix <= '0;
        end else if (data_pend) begin
            ostat_pix <= ostat_pix + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// tb/tb_conv_stream_ctrl.sv - scoreboard bench for conv_stream_ctrl
module tb_conv_stream_ctrl;
    import conv_pkg::*;

    localparam int DATA_W = 64;
    localparam int IN_CH  = 3;
    localparam int KSIZE  = 3;
    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NW     = IN_CH * KSIZE * KSIZE;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [DATA_W-1:0]        idata = '0;
    logic                     idata_empty = 1'b1;
    logic                     odata_rd;
    logic                     ipara_empty = 1'b0;
    logic                     opara_rd;
    logic                     istart = 1'b0;
    logic                     istride = 1'b0;
    logic [IN_CH*8-1:0]       odata_ch;
    logic                     odata_valid;
    logic [4:0]               orow_cnt;
    logic [4:0]               ocol_cnt;
    logic                     orow_flag;
    logic                     owin_valid;
    logic [IN_CH-1:0]         opara_valid;
    logic                     ifinish_flag = 1'b0;
    logic                     oover_flag;
`ifdef CONV_STREAM_STAT_EN
    logic [$clog2(NPIX+1)-1:0] ostat_pix;
`endif

    conv_stream_ctrl #(
        .DATA_W (DATA_W), .IN_CH (IN_CH), .KSIZE (KSIZE), .IMG_W (IMG_W), .IMG_H (IMG_H)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .idata        (idata),
        .idata_empty  (idata_empty),
        .odata_rd     (odata_rd),
        .ipara_empty  (ipara_empty),
        .opara_rd     (opara_rd),
        .istart       (istart),
        .istride      (istride),
        .odata_ch     (odata_ch),
        .odata_valid  (odata_valid),
        .orow_cnt     (orow_cnt),
        .ocol_cnt     (ocol_cnt),
        .orow_flag    (orow_flag),
        .owin_valid   (owin_valid),
        .opara_valid  (opara_valid),
        .ifinish_flag (ifinish_flag),
        .oover_flag   (oover_flag)
`ifdef CONV_STREAM_STAT_EN
        ,
        .ostat_pix    (ostat_pix)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IN_CH*8-1:0] d;
        int                 row;
        int                 col;
        bit                 win;
    } pix_t;

    pix_t             pix_q[$];
    logic [IN_CH-1:0] wq[$];

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  pix_idx = 0;
    int  wpops = 0;
    bit  stride_m = 1'b0;
    bit  rand_stall = 1'b0;
    int  stall_at = -1;
    int  npix, nwin, nstrobe, nover;
    int  first_rd_cyc, first_val_cyc;
    int  win_r[2], win_c[2];
    int  last_r, last_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: position follows directly from the pixel's index in the frame.
    function automatic pix_t model(input int i, input logic [DATA_W-1:0] w, input bit s);
        pix_t p;
        p.d   = w[IN_CH*8-1:0];
        p.row = i / IMG_W;
        p.col = i % IMG_W;
        p.win = (p.row >= KSIZE-1) && (p.col >= KSIZE-1) &&
                (!s || (((p.row-(KSIZE-1)) % 2 == 0) && ((p.col-(KSIZE-1)) % 2 == 0)));
        return p;
    endfunction

    // FIFO model: a popped word shows on idata the cycle after the pop.
    initial begin : fifo_driver
        bit p_d, p_w;
        logic [DATA_W-1:0] word;
        forever begin
            @(negedge clk);
            p_d = odata_rd;
            p_w = opara_rd;
            if (p_d && first_rd_cyc < 0) first_rd_cyc = cyc;
            @(posedge clk);
            #1;
            if (p_w) begin
                wq.push_back(IN_CH'(1) << (wpops / (KSIZE*KSIZE)));
                wpops++;
            end
            if (p_d) begin
                word  = {$urandom, $urandom};
                idata = word;
                pix_q.push_back(model(pix_idx, word, stride_m));
                pix_idx++;
            end
            if (p_d && (pix_idx - 1 == stall_at)) begin
                idata_empty = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_no_rd", odata_rd, 0);
                    if (k >= 1) begin
                        check("stall_row", orow_cnt, 4);
                        check("stall_col", ocol_cnt, 7);
                    end
                    if (k >= 2) check("stall_valid", odata_valid, 0);
                    @(posedge clk);
                    #1;
                end
                idata_empty = 1'b0;
            end else begin
                idata_empty = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
                ipara_empty = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
        end
    end

    // Monitor: pops and compares whenever the DUT presents a strobe or pixel.
    initial begin : monitor
        pix_t e;
        forever begin
            @(negedge clk);
            if (wq.size() > 0) begin
                check("opara_valid", opara_valid, wq.pop_front());
                nstrobe++;
            end else if (opara_valid != 0) begin
                check("opara_valid_unexpected", opara_valid, 0);
            end
            if (oover_flag) nover++;
            if (odata_valid) begin
                if (pix_q.size() == 0) begin
                    check("pix_unexpected", odata_valid, 0);
                end else begin
                    e = pix_q.pop_front();
                    check("odata_ch", odata_ch, e.d);
                    check("orow_cnt", orow_cnt, e.row);
                    check("ocol_cnt", ocol_cnt, e.col);
                    check("owin_valid", owin_valid, e.win);
                    check("orow_flag", orow_flag, e.row >= KSIZE-1);
                end
                if (first_val_cyc < 0) first_val_cyc = cyc;
                if (owin_valid) begin
                    if (nwin < 2) begin
                        win_r[nwin] = orow_cnt;
                        win_c[nwin] = ocol_cnt;
                    end
                    nwin++;
                end
                last_r = orow_cnt;
                last_c = ocol_cnt;
                npix++;
            end else if (owin_valid) begin
                check("owin_without_valid", owin_valid, 0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_odata_rd"}, odata_rd, 0);
        check({tag, "_opara_rd"}, opara_rd, 0);
        check({tag, "_opara_valid"}, opara_valid, 0);
        check({tag, "_odata_valid"}, odata_valid, 0);
        check({tag, "_odata_ch"}, odata_ch, 0);
        check({tag, "_orow_cnt"}, orow_cnt, 0);
        check({tag, "_ocol_cnt"}, ocol_cnt, 0);
        check({tag, "_orow_flag"}, orow_flag, 0);
        check({tag, "_owin_valid"}, owin_valid, 0);
        check({tag, "_oover_flag"}, oover_flag, 0);
    endtask

    task automatic start_frame(input bit s, input bit rs, input int sa);
        int k;
        @(posedge clk);
        #1;
        stride_m = s; rand_stall = rs; stall_at = sa;
        pix_idx = 0; wpops = 0;
        npix = 0; nwin = 0; nstrobe = 0; nover = 0;
        first_rd_cyc = -1; first_val_cyc = -1;
        istride = s; istart = 1'b1;
        @(posedge clk);
        #1;
        istart = 1'b0;
        k = 0;
        while (nstrobe < NW && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("load_strobes", nstrobe, NW);
        check("load_pops", wpops, NW);
    endtask

    task automatic wait_pix(input int n, input int budget);
        int k = 0;
        while (npix < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("pix_wait_done", npix >= n, 1);
    endtask

    task automatic end_frame(input bit with_start);
        int busy = 0;
        int wp0;
        repeat (4) @(negedge clk);
        check("frame_pops", pix_idx, NPIX);
        check("pix_q_empty", pix_q.size(), 0);
        check("last_row", last_r, IMG_H-1);
        check("last_col", last_c, IMG_W-1);
        check("no_over_before_finish", nover, 0);
        @(posedge clk);
        #1;
        wp0 = wpops;
        ifinish_flag = 1'b1;
        istart = with_start;
        @(posedge clk);
        #1;
        ifinish_flag = 1'b0;
        istart = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (opara_rd || odata_rd) busy++;
        end
        check("over_pulses", nover, 1);
        check("idle_no_rd", busy, 0);
        check("no_reload", wpops, wp0);
    endtask

    initial begin : main
        int k;
        npix = 0; nwin = 0; nstrobe = 0; nover = 0;
        first_rd_cyc = -1; first_val_cyc = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Frame A: stride 1, no stalls
        start_frame(1'b0, 1'b0, -1);
        wait_pix(NPIX, 5000);
        check("latency", first_val_cyc - first_rd_cyc, 2);
        check("win_count_s1", nwin, 900);
        end_frame(1'b0);
`ifdef CONV_STREAM_STAT_EN
        check("ostat_pix", ostat_pix, NPIX);
`endif

        // Frame B: stride 2, random stalls, stray istart/ifinish mid-stream
        start_frame(1'b1, 1'b1, -1);
        wait_pix(200, 5000);
        @(posedge clk);
        #1;
        ifinish_flag = 1'b1;
        istart = 1'b1;
        @(posedge clk);
        #1;
        ifinish_flag = 1'b0;
        istart = 1'b0;
        wait_pix(NPIX, 8000);
        check("win_count_s2", nwin, 225);
        check("win0_row", win_r[0], 2);
        check("win0_col", win_c[0], 2);
        check("win1_row", win_r[1], 2);
        check("win1_col", win_c[1], 4);
        end_frame(1'b0);

        // Frame C: stall at pixel (4,7), then finish together with istart
        start_frame(1'b0, 1'b0, 4*IMG_W + 7);
        wait_pix(NPIX, 5000);
        check("win_count_stall", nwin, 900);
        end_frame(1'b1);

        // Frame D: reset mid-stream, then a full reload and frame
        start_frame(1'b0, 1'b1, -1);
        wait_pix(100, 5000);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pix_q.delete();
        wq.delete();
        @(negedge clk);
        check_all_zero("midreset");
        k = 0;
        repeat (10) begin
            @(negedge clk);
            if (odata_rd || opara_rd || odata_valid || opara_valid != 0) k++;
        end
        check("idle_after_reset", k, 0);
        start_frame(1'b0, 1'b1, -1);
        wait_pix(NPIX, 8000);
        check("win_count_after_reset", nwin, 900);
        end_frame(1'b0);
`ifdef CONV_STREAM_STAT_EN
        check("ostat_pix_after_reset", ostat_pix, NPIX);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
